// File: rtl/fifo_word_serializer.sv
// fifo_word_serializer
// Pops full-width words from a FIFO and replays each one as narrow beats on a
// valid/ready stream. Beats go out LSB slice first, and out_last marks the
// final beat of each word. The next word is reloaded in the same cycle that
// the final beat is accepted, so the output carries one beat per cycle across
// word boundaries.
module fifo_word_serializer #(
  parameter int width     = 8,
  parameter int out_width = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  input  logic [width-1:0]     fifo_read_data,
  output logic                 fifo_pop,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [out_width-1:0] out_data,
  output logic                 out_last,
  output logic                 busy
);

  localparam int n_beats = width / out_width;
  localparam int cnt_w   = (n_beats > 1) ? $clog2(n_beats) : 1;
  localparam logic [cnt_w-1:0] last_idx = cnt_w'(n_beats - 1);

  // SEND means a word is held and its current beat is being offered.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [cnt_w-1:0] cnt_q, cnt_d;
  logic [width-1:0] word_q, word_d;

  logic fire;
  logic last_beat;
  logic pop;

  assign out_valid = (state_q == SEND);
  assign busy      = out_valid;
  assign fire      = out_valid & out_ready;
  assign last_beat = (cnt_q == last_idx);
  assign out_last  = out_valid & last_beat;

  // Reload when empty-handed, or when the final beat leaves this very cycle.
  // Reset blocks the pop so the FIFO is never drained by a discarded word.
  assign pop      = !rst & !fifo_empty & (!out_valid | (fire & last_beat));
  assign fifo_pop = pop;

  // Select the slice addressed by the beat counter.
  always_comb begin
    out_data = '0;
    for (int b = 0; b < n_beats; b++) begin
      if (cnt_q == cnt_w'(b)) begin
        out_data = word_q[b*out_width +: out_width];
      end
    end
  end

  // Next-state logic: a pop takes priority over advancing the beat counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    if (pop) begin
      state_d = SEND;
      cnt_d   = '0;
      word_d  = fifo_read_data;
    end else if (fire) begin
      if (last_beat) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + cnt_w'(1);
      end
    end
  end

  // State registers with synchronous reset discarding any held word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
    end
  end

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Testbench for fifo_word_serializer: a 2-bit-beat instance (a) and a
// full-width-beat instance (b) run side by side. Each one has a queue-based
// FIFO and a beat-list reference model.
module tb_fifo_word_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       out_ready;

  logic       empty_a, pop_a, valid_a, last_a, busy_a;
  logic [7:0] rdata_a;
  logic [1:0] data_a;

  logic       empty_b, pop_b, valid_b, last_b, busy_b;
  logic [7:0] rdata_b;
  logic [7:0] data_b;

  int vectors     = 0;
  int miscompares = 0;

  // FIFO contents and the beats still owed for the current word.
  logic [7:0] fq_a[$], fq_b[$];
  logic [7:0] cur_a[$], cur_b[$];

  always #5 clk = ~clk;

  fifo_word_serializer #(.width(8), .out_width(2)) dut_a (
    .clk(clk), .rst(rst), .fifo_empty(empty_a), .fifo_read_data(rdata_a),
    .fifo_pop(pop_a), .out_valid(valid_a), .out_ready(out_ready),
    .out_data(data_a), .out_last(last_a), .busy(busy_a)
  );

  fifo_word_serializer #(.width(8), .out_width(8)) dut_b (
    .clk(clk), .rst(rst), .fifo_empty(empty_b), .fifo_read_data(rdata_b),
    .fifo_pop(pop_b), .out_valid(valid_b), .out_ready(out_ready),
    .out_data(data_b), .out_last(last_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check against the model, then advance the
  // model across the rising edge. Called just after a falling edge.
  task automatic step(input logic r, input logic rdy);
    logic ev_a, el_a, ep_a, ev_b, el_b, ep_b;
    logic [7:0] w;
    rst       = r;
    out_ready = rdy;
    empty_a   = (fq_a.size() == 0);
    rdata_a   = (fq_a.size() != 0) ? fq_a[0] : 8'h00;
    empty_b   = (fq_b.size() == 0);
    rdata_b   = (fq_b.size() != 0) ? fq_b[0] : 8'h00;
    #1;
    ev_a = (cur_a.size() != 0);
    el_a = (cur_a.size() == 1);
    ep_a = !r && (fq_a.size() != 0) && (!ev_a || (rdy && el_a));
    ev_b = (cur_b.size() != 0);
    el_b = (cur_b.size() == 1);
    ep_b = !r && (fq_b.size() != 0) && (!ev_b || (rdy && el_b));
    chk("a_valid", {7'd0, valid_a}, {7'd0, ev_a});
    chk("a_busy",  {7'd0, busy_a},  {7'd0, ev_a});
    chk("a_last",  {7'd0, last_a},  {7'd0, ev_a && el_a});
    chk("a_pop",   {7'd0, pop_a},   {7'd0, ep_a});
    if (ev_a) chk("a_data", {6'd0, data_a}, cur_a[0]);
    chk("b_valid", {7'd0, valid_b}, {7'd0, ev_b});
    chk("b_last",  {7'd0, last_b},  {7'd0, ev_b && el_b});
    chk("b_pop",   {7'd0, pop_b},   {7'd0, ep_b});
    if (ev_b) chk("b_data", data_b, cur_b[0]);
    @(posedge clk);
    if (r) begin
      cur_a.delete();
      cur_b.delete();
    end else begin
      if (ep_a) begin
        w = fq_a.pop_front();
        cur_a.delete();
        for (int i = 0; i < 4; i++) cur_a.push_back((w >> (2 * i)) & 8'h03);
      end else if (ev_a && rdy) begin
        void'(cur_a.pop_front());
      end
      if (ep_b) begin
        w = fq_b.pop_front();
        cur_b.delete();
        cur_b.push_back(w);
      end else if (ev_b && rdy) begin
        void'(cur_b.pop_front());
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b0;
    empty_a = 1'b1; rdata_a = 8'h00; empty_b = 1'b1; rdata_b = 8'h00;
    @(posedge clk);
    @(negedge clk);
    // Reset state
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);

    // Single word 0xB4: beats 0,1,3,2 then idle
    fq_a.push_back(8'hB4);
    repeat (7) step(1'b0, 1'b1);

    // Back-to-back words, no bubble between them
    fq_a.push_back(8'hB4); fq_a.push_back(8'h1E);
    repeat (11) step(1'b0, 1'b1);

    // Backpressure pattern once the word is loaded
    fq_a.push_back(8'hB4);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b1);
    step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b1);

    // Empty idle for 10 cycles, then a late arrival
    repeat (10) step(1'b0, 1'b1);
    fq_a.push_back(8'h5A);
    repeat (6) step(1'b0, 1'b1);

    // Reset on the second beat; the next word starts clean from beat 0
    fq_a.push_back(8'hB4); fq_a.push_back(8'h1E);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    repeat (6) step(1'b0, 1'b1);

    // Full-width beats: three words, every beat last, pops back-to-back
    fq_b.push_back(8'h11); fq_b.push_back(8'h22); fq_b.push_back(8'h33);
    repeat (5) step(1'b0, 1'b1);

    // Randomized traffic, backpressure and occasional reset
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(2, 0) == 0) fq_a.push_back(8'($urandom));
      if ($urandom_range(2, 0) == 0) fq_b.push_back(8'($urandom));
      step(($urandom_range(39, 0) == 0), ($urandom_range(3, 0) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
